// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 panel scan controller.
// Holds the row phase encoding, the rgb bit positions and the default geometry.
package hub75_pkg;

  typedef enum logic [1:0] {
    PH_SHIFT,
    PH_BLANK,
    PH_LATCH,
    PH_SHOW
  } phase_t;

  // Bit positions inside rgb = {R1,G1,B1,R2,G2,B2}
  localparam int RGB_R1 = 5;
  localparam int RGB_G1 = 4;
  localparam int RGB_B1 = 3;
  localparam int RGB_R2 = 2;
  localparam int RGB_G2 = 1;
  localparam int RGB_B2 = 0;

  localparam int DEF_COLS      = 32;
  localparam int DEF_ROWS_HALF = 8;
  localparam int DEF_BRIGHT_W  = 4;
  localparam int DEF_UNIT      = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hub75_oe_pwm.sv
// Output-enable PWM for the SHOW phase: oe is low (lit) for the first
// bright_q*UNIT cycles of SHOW and high (blank) otherwise.
module hub75_oe_pwm
  import hub75_pkg::*;
#(
  parameter int BRIGHT_W = DEF_BRIGHT_W,
  parameter int UNIT     = DEF_UNIT,
  parameter int CNT_W    = 8
) (
  input  logic                show,
  input  logic [CNT_W-1:0]    idx,
  input  logic [BRIGHT_W-1:0] bright_q,
  output logic                oe
);

  logic [31:0] on_len;

  always_comb begin
    on_len = 32'(bright_q) * 32'(UNIT);
    oe     = !(show && (32'(idx) < on_len));
  end

endmodule

// File: rtl/hub75_scan.sv
// HUB75 scan controller: per row SHIFT -> BLANK -> LATCH -> SHOW, with
// framebuffer addressing, binary-weighted brightness and frame-aligned bank swap.
module hub75_scan
  import hub75_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS_HALF = DEF_ROWS_HALF,
  parameter int BRIGHT_W  = DEF_BRIGHT_W,
  parameter int UNIT      = DEF_UNIT
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [$clog2(COLS)-1:0]       pix_col,
  output logic [$clog2(ROWS_HALF)-1:0]  pix_row,
  output logic                          pix_buf,
  input  logic [2:0]                    pix_top,
  input  logic [2:0]                    pix_bot,
  input  logic [BRIGHT_W-1:0]           bright,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic                          frame_start,
  output logic [5:0]                    rgb,
  output logic                          outclk,
  output logic                          lat,
  output logic                          oe,
  output logic [$clog2(ROWS_HALF)-1:0]  abc
);

  localparam int COL_W     = $clog2(COLS);
  localparam int ROW_W     = $clog2(ROWS_HALF);
  localparam int SHIFT_LEN = 2 * COLS + 2;
  localparam int SHOW_LEN  = (2 ** BRIGHT_W) * UNIT;
  localparam int CNT_W     = $clog2(max2(SHIFT_LEN, SHOW_LEN));

  phase_t              phase, phase_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [ROW_W-1:0]    row, row_n;
  logic                buf_sel, buf_n;
  logic [BRIGHT_W-1:0] bright_q;
  logic [5:0]          rgb_q, rgb_n;
  logic [ROW_W-1:0]    abc_q, abc_n;
  logic                oe_pwm;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= PH_SHIFT;
      cnt      <= '0;
      row      <= '0;
      buf_sel  <= 1'b0;
      rgb_q    <= '0;
      abc_q    <= '0;
      bright_q <= bright;
    end else begin
      phase   <= phase_n;
      cnt     <= cnt_n;
      row     <= row_n;
      buf_sel <= buf_n;
      rgb_q   <= rgb_n;
      abc_q   <= abc_n;
      if (frame_start) bright_q <= bright;
    end
  end

  always_comb begin
    phase_n     = phase;
    cnt_n       = cnt + 1'b1;
    row_n       = row;
    buf_n       = buf_sel;
    rgb_n       = rgb_q;
    abc_n       = abc_q;
    swap_ack    = 1'b0;
    frame_start = 1'b0;
    lat         = 1'b0;
    outclk      = 1'b0;
    pix_col     = COL_W'(COLS - 1);
    unique case (phase)
      PH_SHIFT: begin
        frame_start = (cnt == '0) && (row == '0);
        if (cnt < CNT_W'(2 * COLS)) pix_col = cnt[COL_W:1];
        // Shift clock rises one cycle after each column lands on rgb
        outclk = cnt[0] && (cnt >= CNT_W'(3));
        if (cnt[0] && (cnt < CNT_W'(2 * COLS))) begin
          rgb_n         = '0;
          rgb_n[RGB_R1] = pix_top[2];
          rgb_n[RGB_G1] = pix_top[1];
          rgb_n[RGB_B1] = pix_top[0];
          rgb_n[RGB_R2] = pix_bot[2];
          rgb_n[RGB_G2] = pix_bot[1];
          rgb_n[RGB_B2] = pix_bot[0];
        end
        if (cnt == CNT_W'(SHIFT_LEN - 1)) begin
          rgb_n   = '0;
          abc_n   = row;
          phase_n = PH_BLANK;
          cnt_n   = '0;
        end
      end
      PH_BLANK: begin
        phase_n = PH_LATCH;
        cnt_n   = '0;
      end
      PH_LATCH: begin
        lat     = !reset;
        phase_n = PH_SHOW;
        cnt_n   = '0;
      end
      PH_SHOW: begin
        if (cnt == CNT_W'(SHOW_LEN - 1)) begin
          phase_n = PH_SHIFT;
          cnt_n   = '0;
          row_n   = row + 1'b1;
          // Bank flips only on the final cycle of the frame
          if ((row == ROW_W'(ROWS_HALF - 1)) && swap_req) begin
            buf_n    = !buf_sel;
            swap_ack = !reset;
          end
        end
      end
      default: begin
        phase_n = PH_SHIFT;
        cnt_n   = '0;
      end
    endcase
  end

  hub75_oe_pwm #(
    .BRIGHT_W (BRIGHT_W),
    .UNIT     (UNIT),
    .CNT_W    (CNT_W)
  ) u_oe_pwm (
    .show     (phase == PH_SHOW),
    .idx      (cnt),
    .bright_q (bright_q),
    .oe       (oe_pwm)
  );

  assign oe      = oe_pwm | reset;
  assign rgb     = rgb_q;
  assign abc     = abc_q;
  assign pix_row = row;
  assign pix_buf = buf_sel;

endmodule

// File: tb/tb_hub75_scan.sv
// Self-checking bench for hub75_scan at default geometry: cycle-indexed
// reference timing, vector table of brightness/swap runs, directed corner cases.
module tb_hub75_scan;

  localparam int COLS  = 32;
  localparam int RH    = 8;
  localparam int UNIT  = 4;
  localparam int ROWP  = 132;
  localparam int FRAME = 1056;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] pix_col;
  logic [2:0] pix_row;
  logic       pix_buf;
  logic [2:0] pix_top = '0;
  logic [2:0] pix_bot = '0;
  logic [3:0] bright = 4'd5;
  logic       swap_req = 1'b0;
  logic       swap_ack, frame_start, outclk, lat, oe;
  logic [5:0] rgb;
  logic [2:0] abc;

  hub75_scan #(
    .COLS      (32),
    .ROWS_HALF (8),
    .BRIGHT_W  (4),
    .UNIT      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_col     (pix_col),
    .pix_row     (pix_row),
    .pix_buf     (pix_buf),
    .pix_top     (pix_top),
    .pix_bot     (pix_bot),
    .bright      (bright),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .rgb         (rgb),
    .outclk      (outclk),
    .lat         (lat),
    .oe          (oe),
    .abc         (abc)
  );

  always #5 clk = ~clk;

  // Framebuffer: one-cycle read latency, pixel derived from column and bank
  always @(posedge clk) begin
    pix_top <= pix_col[2:0] ^ {3{pix_buf}};
    pix_bot <= ~(pix_col[2:0] ^ {3{pix_buf}});
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int mbq = 0;
  bit mbuf = 1'b0;
  int e_oe, e_lat, e_clk, e_abc, e_col, e_row, e_rgb, e_fs, e_ack, e_buf, e_abcoe;
  int n_rise, n_lat, n_oelow, n_ack, n_fs, first_lat, first_ack, last_ack;
  logic       prev_clk;
  logic [2:0] prev_abc;

  int m_k, m_r, m_c, x_abc, x_col;
  logic x_oe, x_lat, x_clk, x_fs, x_ack;
  logic [2:0] t;
  logic [5:0] x_rgb;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    e_oe = 0; e_lat = 0; e_clk = 0; e_abc = 0; e_col = 0; e_row = 0;
    e_rgb = 0; e_fs = 0; e_ack = 0; e_buf = 0; e_abcoe = 0;
    n_rise = 0; n_lat = 0; n_oelow = 0; n_ack = 0; n_fs = 0;
    first_lat = -1; first_ack = -1; last_ack = -1;
    prev_clk = 1'b0; prev_abc = 3'd0;
  endtask

  // Reference timing derived only from the cycle index since reset
  always @(negedge clk) begin
    if (mon_en) begin
      m_k   = cyc % ROWP;
      m_r   = (cyc / ROWP) % RH;
      x_oe  = (m_k < 68) ? 1'b1 : (((m_k - 68) < mbq * UNIT) ? 1'b0 : 1'b1);
      x_lat = (m_k == 67);
      x_clk = (m_k >= 3) && (m_k <= 65) && (m_k % 2 == 1);
      x_fs  = (cyc % FRAME == 0);
      x_ack = (m_k == ROWP - 1) && (m_r == RH - 1) && swap_req;
      x_abc = (m_k >= 66) ? m_r : ((cyc < 66) ? 0 : (m_r + RH - 1) % RH);
      x_col = (m_k < 64) ? m_k / 2 : COLS - 1;
      if (m_k >= 2 && m_k <= 65) begin
        m_c   = (m_k - 2) / 2;
        t     = m_c[2:0] ^ {3{mbuf}};
        x_rgb = {t, ~t};
      end else begin
        x_rgb = '0;
      end
      if (oe !== x_oe) e_oe++;
      if (lat !== x_lat) e_lat++;
      if (outclk !== x_clk) e_clk++;
      if (frame_start !== x_fs) e_fs++;
      if (swap_ack !== x_ack) e_ack++;
      if (abc !== 3'(x_abc)) e_abc++;
      if (pix_col !== 5'(x_col)) e_col++;
      if (pix_row !== 3'(m_r)) e_row++;
      if (rgb !== x_rgb) e_rgb++;
      if (pix_buf !== mbuf) e_buf++;
      if ((abc !== prev_abc) && !oe) e_abcoe++;
      if (outclk && !prev_clk) n_rise++;
      if (lat) begin
        if (n_lat == 0) first_lat = cyc;
        n_lat++;
      end
      if (!oe) n_oelow++;
      if (frame_start) n_fs++;
      if (swap_ack) begin
        if (n_ack == 0) first_ack = cyc;
        last_ack = cyc;
        n_ack++;
      end
      prev_clk = outclk;
      prev_abc = abc;
      if (x_fs) mbq = int'(bright);
      if (x_ack) mbuf = ~mbuf;
    end
  end

  task automatic do_reset(input int n);
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset  = 1'b0;
    cyc    = 0;
    mbuf   = 1'b0;
    mbq    = int'(bright);
    clr_stats();
    mon_en = 1'b1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_oe"}, e_oe, 0);
    chk({tag, "_lat"}, e_lat, 0);
    chk({tag, "_outclk"}, e_clk, 0);
    chk({tag, "_frame_start"}, e_fs, 0);
    chk({tag, "_swap_ack"}, e_ack, 0);
    chk({tag, "_abc"}, e_abc, 0);
    chk({tag, "_pix_col"}, e_col, 0);
    chk({tag, "_pix_row"}, e_row, 0);
    chk({tag, "_rgb"}, e_rgb, 0);
    chk({tag, "_pix_buf"}, e_buf, 0);
    chk({tag, "_abc_while_lit"}, e_abcoe, 0);
  endtask

  typedef struct {
    int bright;
    bit swap;
    int ncyc;
    int x_oelow;
    int x_rise;
    int x_lat;
    int x_ack;
  } vec_t;

  vec_t vt[5];
  int   saved;

  initial begin
    vt[0] = '{5,  1'b0, 1056, 160, 256, 8,  0};
    vt[1] = '{0,  1'b0, 1056, 0,   256, 8,  0};
    vt[2] = '{15, 1'b0, 1056, 480, 256, 8,  0};
    vt[3] = '{1,  1'b0, 264,  8,   64,  2,  0};
    vt[4] = '{5,  1'b1, 2112, 320, 512, 16, 2};

    // Reset state and first-row landmarks
    bright = 4'd7;
    do_reset(3);
    chk("rst_frame_start", int'(frame_start), 1);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_outclk", int'(outclk), 0);
    chk("rst_lat", int'(lat), 0);
    chk("rst_oe", int'(oe), 1);
    chk("rst_abc", int'(abc), 0);
    chk("rst_swap_ack", int'(swap_ack), 0);
    chk("rst_pix_col", int'(pix_col), 0);
    chk("rst_pix_row", int'(pix_row), 0);
    chk("rst_pix_buf", int'(pix_buf), 0);
    run_to(2);
    chk("c2_rgb_col0", int'(rgb), 'h07);
    run_to(3);
    chk("c3_outclk", int'(outclk), 1);
    chk("c3_rgb_col0", int'(rgb), 'h07);
    run_to(65);
    chk("c65_rgb_col31", int'(rgb), 'h38);
    run_to(66);
    chk("c66_rgb_zero", int'(rgb), 0);
    run_to(67);
    chk("c67_lat", int'(lat), 1);
    run_to(199);
    chk("c199_lat_row1", int'(lat), 1);

    // Vector table: brightness and swap runs from reset
    for (int i = 0; i < 5; i++) begin
      bright   = 4'(vt[i].bright);
      swap_req = vt[i].swap;
      do_reset(2);
      run_to(vt[i].ncyc);
      chk($sformatf("v%0d_oe_low", i), n_oelow, vt[i].x_oelow);
      chk($sformatf("v%0d_rises", i), n_rise, vt[i].x_rise);
      chk($sformatf("v%0d_lats", i), n_lat, vt[i].x_lat);
      chk($sformatf("v%0d_acks", i), n_ack, vt[i].x_ack);
      chk($sformatf("v%0d_first_lat", i), first_lat, 67);
      chk($sformatf("v%0d_frames", i), n_fs, (vt[i].ncyc + FRAME - 1) / FRAME);
      check_model($sformatf("v%0d", i));
    end
    swap_req = 1'b0;

    // Swap requested mid-frame and held across two frames
    bright = 4'd5;
    do_reset(2);
    run_to(500);
    swap_req = 1'b1;
    run_to(1055);
    chk("swap_ack_1055", int'(swap_ack), 1);
    chk("swap_buf_1055", int'(pix_buf), 0);
    run_to(1056);
    chk("swap_buf_1056", int'(pix_buf), 1);
    chk("swap_ack_1056", int'(swap_ack), 0);
    run_to(2111);
    chk("swap_ack_2111", int'(swap_ack), 1);
    run_to(2112);
    chk("swap_buf_2112", int'(pix_buf), 0);
    swap_req = 1'b0;
    run_to(3168);
    chk("swap_ack_count", n_ack, 2);
    chk("swap_first_ack", first_ack, 1055);
    chk("swap_last_ack", last_ack, 2111);
    check_model("swap");

    // Brightness change mid-frame applies from the next frame only
    bright = 4'd5;
    do_reset(2);
    run_to(300);
    bright = 4'd10;
    run_to(1056);
    chk("bright_frame0_low", n_oelow, 160);
    saved = n_oelow;
    run_to(2112);
    chk("bright_frame1_low", n_oelow - saved, 320);
    check_model("bright");

    // Reset during SHOW cycle 10 of row 3 with bank 1 displayed
    bright   = 4'd5;
    swap_req = 1'b1;
    do_reset(2);
    run_to(1056);
    swap_req = 1'b0;
    run_to(1530);
    chk("pre_rst_oe_lit", int'(oe), 0);
    chk("pre_rst_buf", int'(pix_buf), 1);
    check_model("pre_rst");
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("in_rst_lat", int'(lat), 0);
    chk("in_rst_swap_ack", int'(swap_ack), 0);
    do_reset(1);
    chk("post_rst_oe", int'(oe), 1);
    chk("post_rst_abc", int'(abc), 0);
    chk("post_rst_buf", int'(pix_buf), 0);
    chk("post_rst_lat", int'(lat), 0);
    chk("post_rst_row", int'(pix_row), 0);
    chk("post_rst_frame_start", int'(frame_start), 1);
    run_to(1056);
    chk("post_rst_lats", n_lat, 8);
    chk("post_rst_first_lat", first_lat, 67);
    check_model("post_rst");

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_scan.md
HUB75_SCAN -- requirements
Module: hub75_scan

Interface
REQ-001 SHALL have parameters: COLS, default 32, panel width in columns.
REQ-002 SHALL have parameter ROWS_HALF, default 8, scan rows; panel height is 2*ROWS_HALF; must be a power of 2.
REQ-003 SHALL have parameter BRIGHT_W, default 4, brightness code width.
REQ-004 SHALL have parameter UNIT, default 4, SHOW cycles per brightness step.
REQ-005 SHALL have ports as follows; derived widths are COL_W = clog2(COLS) and ROW_W = clog2(ROWS_HALF).
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pix_col  out  COL_W  framebuffer column read address.
- pix_row  out  ROW_W  framebuffer scan-row read address.
- pix_buf  out  1  framebuffer bank being displayed (= buf_sel).
- pix_top  in  3  RGB of (pix_row, pix_col), valid 1 cycle after address.
- pix_bot  in  3  RGB of (pix_row+ROWS_HALF, pix_col), same timing.
- bright  in  BRIGHT_W  brightness code; 0 = dark.
- swap_req  in  1  level request to flip display bank.
- swap_ack  out  1  one-cycle pulse when the bank flips.
- frame_start  out  1  one-cycle pulse, first SHIFT cycle of row 0.
- rgb  out  6  {R1,G1,B1,R2,G2,B2} panel data.
- outclk  out  1  panel shift clock.
- lat  out  1  panel latch.
- oe  out  1  panel output enable, active-low (1 = blank).
- abc  out  ROW_W  panel row select.

Function
REQ-006 SHALL sequence each scan row through SHIFT (2*COLS+2 cycles) -> BLANK (1) -> LATCH (1) -> SHOW (2^BRIGHT_W*UNIT cycles), then SHIFT of the next row.
REQ-007 In SHIFT cycle k, SHALL drive pix_col = k/2 on even k < 2*COLS and hold it otherwise.
REQ-008 SHALL register {pix_top,pix_bot} into rgb at the end of each odd SHIFT cycle 2c+1 (c < COLS), so column c is stable on rgb during cycles 2c+2 and 2c+3.
REQ-009 SHALL drive outclk=1 in SHIFT cycles 3,5,...,2*COLS+1 and 0 in all other cycles, giving exactly COLS rising edges per row, each centred on stable data.
REQ-010 SHALL hold pix_row = current scan row r for the whole row period.
REQ-011 SHALL hold oe=1 in SHIFT, BLANK and LATCH.
REQ-012 SHALL update abc to r in the BLANK cycle, with oe=1.
REQ-013 SHALL assert lat=1 only in the LATCH cycle.
REQ-014 In SHOW cycle j, SHALL drive oe=0 iff j < bright_q*UNIT; bright_q is bright sampled at frame_start; bright=0 gives oe=1 throughout; max code gives oe=0 for all but UNIT cycles.
REQ-015 SHALL increment r modulo ROWS_HALF after SHOW; wrap ROWS_HALF-1 -> 0 starts a new frame.
REQ-016 In the last SHOW cycle of row ROWS_HALF-1, if swap_req=1, SHALL toggle buf_sel and pulse swap_ack once.
REQ-017 The new bank SHALL take effect from the next frame's first address; no mid-frame bank change SHALL ever occur.
REQ-018 swap_req held high across several frames SHALL flip the bank once per frame; swap_req low SHALL never pulse swap_ack.
REQ-019 rgb SHALL be 0 outside SHIFT cycles 2..2*COLS+1.
REQ-020 The row period SHALL be 2*COLS+4+2^BRIGHT_W*UNIT cycles (132 at defaults); the frame SHALL be ROWS_HALF times that (1056).

Reset
REQ-021 On reset, next cycle SHALL be SHIFT cycle 0 of row 0 with frame_start=1; values after reset: rgb=0, outclk=0, lat=0, oe=1, abc=0, buf_sel=0, swap_ack=0, pix_col=0, pix_row=0, bright_q=bright.
REQ-022 Reset asserted mid-SHOW or mid-SHIFT SHALL abort the row with no lat pulse and no swap, and blank immediately (oe=1 in the cycle after reset).

Structure
REQ-023 A shared package hub75_pkg SHALL hold the phase enum (SHIFT, BLANK, LATCH, SHOW), the RGB-bit index constants and default parameter values.
REQ-024 One sub-module SHALL be used: hub75_oe_pwm, computing oe from SHOW cycle index, bright_q and UNIT.

Verification
REQ-025 Defaults with framebuffer model (pixel = col parity): reset -> frame_start at cycle 0, 32 outclk rises per row, lat at cycle 67, row period 132, frame 1056.
REQ-026 Column test: pix_top = col[2:0], pix_bot = ~col[2:0] -> at each outclk rise, rgb equals {c[2:0], ~c[2:0]} for c = 0..31 in order.
REQ-027 Brightness: bright=5 -> 20 oe-low cycles per row; bright=0 -> oe never low; bright changed mid-frame takes effect at the next frame_start only.
REQ-028 Swap: swap_req pulsed mid-frame 0 and held -> swap_ack at cycle 1055, pix_buf=1 from cycle 1056; if still held, flips again at 2111.
REQ-029 Row wrap: abc sequence 0..7,0 over 9 rows, with abc changing only where oe=1.
REQ-030 Reset at SHOW cycle 10 of row 3 -> oe=1 next cycle, abc=0, buf_sel=0, no lat, restart at row 0.
